// File: rtl/line_refill_ctrl_if.sv
// Single-beat system bus between the line refill controller (master) and memory (slave).
interface line_refill_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback, then a word-by-word refill.
// Define REFILL_CRITICAL_WORD_FIRST_EN to start the refill at the missing word and wrap.
module line_refill_ctrl #(
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned LINE_LSB  = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            line_miss_i,
    input  logic                            replace_dirty_i,
    input  logic [SEL_WIDTH-1:0]            entry_replace_sel_i,
    input  logic [31:0]                     miss_addr_i,
    input  logic [31:0]                     victim_pa_i,
    output logic [31:0]                     refill_pa_o,
    output logic                            line_refill_o,
    output logic                            writeback_complete_o,
    output logic                            busy_o,
    output logic [SEL_WIDTH+LINE_LSB-3:0]   cmem_addr_o,
    output logic                            cmem_we_o,
    output logic [31:0]                     cmem_wdata_o,
    input  logic [31:0]                     cmem_rdata_i,
    line_refill_ctrl_if.master              bus
);
    localparam int unsigned IDX_W = LINE_LSB - 2;

    typedef enum logic [2:0] {StIdle, StWbRd, StWbBus, StRfBus, StRfWr, StDone} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     start_q, start_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [31:LINE_LSB]   miss_q, miss_d;
    logic [31:LINE_LSB]   victim_q, victim_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 wb_first_q, wb_first_d;
    logic                 wbc_q, wbc_d;
    logic [IDX_W-1:0]     start_idx;
    logic                 unused_bits;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_addr_i[LINE_LSB-1:2];
`else
    assign start_idx = '0;
`endif

    assign unused_bits = ^{miss_addr_i[LINE_LSB-1:0], victim_pa_i[LINE_LSB-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            start_q    <= '0;
            sel_q      <= '0;
            miss_q     <= '0;
            victim_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wb_first_q <= 1'b0;
            wbc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            sel_q      <= sel_d;
            miss_q     <= miss_d;
            victim_q   <= victim_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wb_first_q <= wb_first_d;
            wbc_q      <= wbc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        start_d       = start_q;
        sel_d         = sel_q;
        miss_d        = miss_q;
        victim_d      = victim_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        wb_first_d    = 1'b0;
        wbc_d         = 1'b0;
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        cmem_we_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (line_miss_i) begin
                    miss_d   = miss_addr_i[31:LINE_LSB];
                    victim_d = victim_pa_i[31:LINE_LSB];
                    sel_d    = entry_replace_sel_i;
                    start_d  = start_idx;
                    cnt_d    = '0;
                    idx_d    = replace_dirty_i ? '0 : start_idx;
                    state_d  = replace_dirty_i ? StWbRd : StRfBus;
                end
            end
            StWbRd: begin
                wb_first_d = 1'b1;
                state_d    = StWbBus;
            end
            StWbBus: begin
                bus.bus_req  = 1'b1;
                bus.bus_we   = 1'b1;
                bus.bus_addr = {victim_q, idx_q, 2'b00};
                // RAM data arrives during the first bus cycle; hold it for the rest of the stall.
                if (wb_first_q) wdata_d = cmem_rdata_i;
                if (bus.bus_ack) begin
                    if (&idx_q) begin
                        wbc_d   = 1'b1;
                        idx_d   = start_q;
                        state_d = StRfBus;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StWbRd;
                    end
                end
            end
            StRfBus: begin
                bus.bus_req  = 1'b1;
                bus.bus_addr = {miss_q, idx_q, 2'b00};
                if (bus.bus_ack) begin
                    rdata_d = bus.bus_rdata;
                    state_d = StRfWr;
                end
            end
            StRfWr: begin
                cmem_we_o = 1'b1;
                idx_d     = idx_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                state_d   = (&cnt_q) ? StDone : StRfBus;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.bus_wdata        = (state_q == StWbBus && wb_first_q) ? cmem_rdata_i : wdata_q;
    assign cmem_addr_o          = {sel_q, idx_q};
    assign cmem_wdata_o         = rdata_q;
    assign refill_pa_o          = {miss_q, {LINE_LSB{1'b0}}};
    assign line_refill_o        = (state_q == StDone);
    assign writeback_complete_o = wbc_q;
    assign busy_o               = (state_q != StIdle);
endmodule
